// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants and the update-scheduler state encoding.
// The sync generator and the frame update scheduler both import this package.
package vga_timing_pkg;

   localparam int HD = 640;
   localparam int HF = 48;
   localparam int HB = 16;
   localparam int HR = 96;
   localparam int VD = 480;
   localparam int VF = 10;
   localparam int VB = 33;
   localparam int VR = 2;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      SERVE
   } state_t;

endpackage

// File: rtl/frame_update_scheduler_if.sv
// Request/grant/done bundle between the scheduler (master) and the game objects (slave).
interface frame_update_scheduler_if #(
   parameter int N_REQ = 4
);

   logic [N_REQ-1:0] upd_req;
   logic [N_REQ-1:0] upd_done;
   logic [N_REQ-1:0] upd_grant;

   modport master (
      input  upd_req,
      input  upd_done,
      output upd_grant
   );

   modport slave (
      output upd_req,
      output upd_done,
      input  upd_grant
   );

endinterface

// File: rtl/frame_update_scheduler_picker.sv
// Combinational lowest-set-bit picker: one-hot select, binary index and a valid flag.
module lowest_set_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] mask,
   output logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = |mask;
      // Walk from the top down so the last hit, the lowest index, wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (mask[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/frame_update_scheduler.sv
// Runs per-frame object updates one at a time inside vertical blanking,
// with a per-grant timeout and an abort when the visible region restarts.
module frame_update_scheduler
   import vga_timing_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int VD      = vga_timing_pkg::VD,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          p_tick,
   input  logic [10:0]                   pixel_x,
   input  logic [10:0]                   pixel_y,
   frame_update_scheduler_if.master      bus,
   input  logic                          clr_err,
   output logic                          frame_tick,
   output logic [CNT_W-1:0]              frame_count,
   output logic                          busy,
   output logic                          timeout_err,
   output logic                          overrun_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [10:0]   VD_Y  = 11'(VD);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   pending_q, pending_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic               frame_tick_q, frame_tick_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               timeout_err_q, timeout_err_d;
   logic               overrun_err_q, overrun_err_d;
   logic               to_set, ov_set;

   logic               vb_start, act_start;
   logic [N_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   assign vb_start  = p_tick && (pixel_x == 11'd0) && (pixel_y == VD_Y);
   assign act_start = p_tick && (pixel_x == 11'd0) && (pixel_y == 11'd0);

   lowest_set_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .mask   (pending_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      frame_tick_d = 1'b0;
      count_d      = count_q;
      timer_d      = timer_q;
      to_set       = 1'b0;
      ov_set       = 1'b0;

      case (state_q)
         IDLE: begin
            if (vb_start) begin
               pending_d    = bus.upd_req;
               frame_tick_d = 1'b1;
               count_d      = count_q + CNT_W'(1);
               state_d      = SCAN;
            end
         end
         SCAN: begin
            if (act_start) begin
               grant_d   = '0;
               pending_d = '0;
               ov_set    = 1'b1;
               state_d   = IDLE;
            end else if (!pick_valid) begin
               state_d = IDLE;
            end else begin
               grant_d   = pick_onehot;
               gidx_d    = pick_idx;
               pending_d = pending_q & ~pick_onehot;
               timer_d   = '0;
               state_d   = SERVE;
            end
         end
         SERVE: begin
            timer_d = timer_q + TW'(1);
            // Abort outranks a same-cycle done or timeout.
            if (act_start) begin
               grant_d   = '0;
               pending_d = '0;
               ov_set    = 1'b1;
               state_d   = IDLE;
            end else if (bus.upd_done[gidx_q]) begin
               grant_d = '0;
               state_d = SCAN;
            end else if (timer_q == T_MAX) begin
               grant_d = '0;
               to_set  = 1'b1;
               state_d = SCAN;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase

      timeout_err_d = to_set | (timeout_err_q & ~clr_err);
      overrun_err_d = ov_set | (overrun_err_q & ~clr_err);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pending_q     <= '0;
         grant_q       <= '0;
         gidx_q        <= '0;
         frame_tick_q  <= 1'b0;
         count_q       <= '0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         grant_q       <= grant_d;
         gidx_q        <= gidx_d;
         frame_tick_q  <= frame_tick_d;
         count_q       <= count_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign bus.upd_grant = grant_q;
   assign frame_tick    = frame_tick_q;
   assign frame_count   = count_q;
   assign busy          = (state_q != IDLE);
   assign timeout_err   = timeout_err_q;
   assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: a per-cycle vector table for the
// basic frame sequence plus hand-written timeout, abort, late-request, wrap and reset cases.
module tb_frame_update_scheduler;

   // Narrow frame counter keeps the wrap case short.
   localparam int CNT_W = 10;

   logic             clk = 1'b0;
   logic             reset;
   logic             p_tick;
   logic [10:0]      pixel_x;
   logic [10:0]      pixel_y;
   logic             clr_err;
   logic             frame_tick;
   logic [CNT_W-1:0] frame_count;
   logic             busy;
   logic             timeout_err;
   logic             overrun_err;

   frame_update_scheduler_if #(.N_REQ(4)) bif ();

   frame_update_scheduler #(
      .N_REQ   (4),
      .VD      (480),
      .TIMEOUT (16),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .p_tick      (p_tick),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .bus         (bif),
      .clr_err     (clr_err),
      .frame_tick  (frame_tick),
      .frame_count (frame_count),
      .busy        (busy),
      .timeout_err (timeout_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [CNT_W-1:0] exp_cnt;

   typedef struct {
      int               ev;      // 0 none, 1 vb_start, 2 vb position without p_tick
      logic [3:0]       req;
      logic [3:0]       done;
      logic [3:0]       grant;
      logic             ftick;
      logic             bsy;
      logic [CNT_W-1:0] cnt;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(int ev, logic [3:0] req, logic [3:0] done,
                               logic [3:0] grant, logic ftick, logic bsy, int cnt);
      vec_t v;
      v.ev    = ev;
      v.req   = req;
      v.done  = done;
      v.grant = grant;
      v.ftick = ftick;
      v.bsy   = bsy;
      v.cnt   = CNT_W'(cnt);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      p_tick  = 1'b1;
      pixel_x = 11'd5;
      pixel_y = 11'd100;
   endtask

   task automatic drive_vb();
      p_tick  = 1'b1;
      pixel_x = 11'd0;
      pixel_y = 11'd480;
      step();
      set_idle();
      exp_cnt = exp_cnt + 1'b1;
   endtask

   task automatic serve_one(input logic [3:0] exp_g, input string name);
      int n;
      n = 0;
      step();
      while (bif.upd_grant == 4'b0000 && n < 4) begin
         step();
         n++;
      end
      chk(name, bif.upd_grant, exp_g);
      bif.upd_done = bif.upd_grant;
      step();
      bif.upd_done = 4'b0000;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic seen;

      vecs[0]  = mk(1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b1, 1);
      vecs[1]  = mk(0, 4'b1011, 4'b0000, 4'b0001, 1'b0, 1'b1, 1);
      vecs[2]  = mk(0, 4'b1011, 4'b0000, 4'b0001, 1'b0, 1'b1, 1);
      vecs[3]  = mk(0, 4'b1011, 4'b0000, 4'b0001, 1'b0, 1'b1, 1);
      vecs[4]  = mk(0, 4'b1011, 4'b0001, 4'b0000, 1'b0, 1'b1, 1);
      vecs[5]  = mk(0, 4'b1011, 4'b0000, 4'b0010, 1'b0, 1'b1, 1);
      vecs[6]  = mk(0, 4'b1011, 4'b1001, 4'b0010, 1'b0, 1'b1, 1);
      vecs[7]  = mk(0, 4'b1011, 4'b0000, 4'b0010, 1'b0, 1'b1, 1);
      vecs[8]  = mk(0, 4'b1011, 4'b0010, 4'b0000, 1'b0, 1'b1, 1);
      vecs[9]  = mk(0, 4'b1011, 4'b0000, 4'b1000, 1'b0, 1'b1, 1);
      vecs[10] = mk(0, 4'b1011, 4'b0000, 4'b1000, 1'b0, 1'b1, 1);
      vecs[11] = mk(0, 4'b1011, 4'b0000, 4'b1000, 1'b0, 1'b1, 1);
      vecs[12] = mk(0, 4'b1011, 4'b1000, 4'b0000, 1'b0, 1'b1, 1);
      vecs[13] = mk(0, 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
      vecs[14] = mk(2, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1);
      vecs[15] = mk(1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2);
      vecs[16] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2);
      vecs[17] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2);

      reset        = 1'b1;
      clr_err      = 1'b0;
      bif.upd_req  = 4'b0000;
      bif.upd_done = 4'b0000;
      set_idle();
      step();
      step();
      reset = 1'b0;
      chk("rst_grant", bif.upd_grant, 4'b0000);
      chk("rst_ftick", frame_tick, 1'b0);
      chk("rst_count", frame_count, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_to", timeout_err, 1'b0);
      chk("rst_ov", overrun_err, 1'b0);

      // Basic frame, done-of-other-requester, p_tick gating, empty frame.
      for (int i = 0; i < 18; i++) begin
         bif.upd_req  = vecs[i].req;
         bif.upd_done = vecs[i].done;
         case (vecs[i].ev)
            1: begin p_tick = 1'b1; pixel_x = 11'd0; pixel_y = 11'd480; end
            2: begin p_tick = 1'b0; pixel_x = 11'd0; pixel_y = 11'd480; end
            default: set_idle();
         endcase
         step();
         chk($sformatf("v%0d_grant", i), bif.upd_grant, vecs[i].grant);
         chk($sformatf("v%0d_ftick", i), frame_tick, vecs[i].ftick);
         chk($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
         chk($sformatf("v%0d_count", i), frame_count, vecs[i].cnt);
      end
      set_idle();
      bif.upd_done = 4'b0000;
      exp_cnt = CNT_W'(2);

      // Timeout on requester 0, then requester 1 served, then clear.
      bif.upd_req = 4'b0011;
      drive_vb();
      chk("t3_ftick", frame_tick, 1'b1);
      step();
      chk("t3_grant0", bif.upd_grant, 4'b0001);
      n = 0;
      while (bif.upd_grant == 4'b0001 && n < 40) begin
         n++;
         step();
      end
      chk("t3_hold", n, 16);
      chk("t3_drop", bif.upd_grant, 4'b0000);
      chk("t3_to_set", timeout_err, 1'b1);
      step();
      chk("t3_grant1", bif.upd_grant, 4'b0010);
      step();
      chk("t3_to_sticky", timeout_err, 1'b1);
      bif.upd_done = 4'b0010;
      step();
      bif.upd_done = 4'b0000;
      chk("t3_grant1_drop", bif.upd_grant, 4'b0000);
      step();
      chk("t3_idle", busy, 1'b0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3_to_clr", timeout_err, 1'b0);

      // Abort beats done; set beats clear; pending discarded.
      bif.upd_req = 4'b0011;
      drive_vb();
      step();
      chk("t4_grant0", bif.upd_grant, 4'b0001);
      p_tick = 1'b1; pixel_x = 11'd0; pixel_y = 11'd0;
      bif.upd_done = 4'b0001;
      clr_err = 1'b1;
      step();
      set_idle();
      bif.upd_done = 4'b0000;
      clr_err = 1'b0;
      chk("t4_grant", bif.upd_grant, 4'b0000);
      chk("t4_ov", overrun_err, 1'b1);
      chk("t4_busy", busy, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bif.upd_grant != 4'b0000 || busy) seen = 1'b1;
      end
      chk("t4_no_more", seen, 1'b0);
      chk("t4_ov_sticky", overrun_err, 1'b1);
      p_tick = 1'b1; pixel_x = 11'd0; pixel_y = 11'd0;
      step();
      set_idle();
      chk("t4_act_idle_busy", busy, 1'b0);
      chk("t4_act_idle_to", timeout_err, 1'b0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t4_ov_clr", overrun_err, 1'b0);

      // Requests raised after vb_start wait for the next frame.
      bif.upd_req = 4'b0001;
      drive_vb();
      bif.upd_req = 4'b1111;
      step();
      chk("t5_grant0", bif.upd_grant, 4'b0001);
      bif.upd_done = 4'b0001;
      step();
      bif.upd_done = 4'b0000;
      chk("t5_drop", bif.upd_grant, 4'b0000);
      step();
      chk("t5_idle", busy, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bif.upd_grant != 4'b0000) seen = 1'b1;
      end
      chk("t5_late_wait", seen, 1'b0);
      drive_vb();
      serve_one(4'b0001, "t5_f2_g0");
      serve_one(4'b0010, "t5_f2_g1");
      serve_one(4'b0100, "t5_f2_g2");
      serve_one(4'b1000, "t5_f2_g3");
      step();
      chk("t5_f2_idle", busy, 1'b0);
      chk("t5_count", frame_count, 6);

      // Frame counter wrap.
      bif.upd_req = 4'b0000;
      n = (1 << CNT_W) - int'(exp_cnt);
      for (int j = 0; j < n - 1; j++) begin
         drive_vb();
         step();
      end
      chk("t6_max", frame_count, {CNT_W{1'b1}});
      drive_vb();
      chk("t6_wrap", frame_count, 0);
      chk("t6_ftick", frame_tick, 1'b1);
      step();

      // Reset while requester 2 holds the grant (after a timeout on 1).
      bif.upd_req = 4'b0110;
      drive_vb();
      step();
      chk("t7_grant1", bif.upd_grant, 4'b0010);
      n = 0;
      while (bif.upd_grant == 4'b0010 && n < 40) begin
         n++;
         step();
      end
      step();
      chk("t7_grant2", bif.upd_grant, 4'b0100);
      chk("t7_to", timeout_err, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t7_grant", bif.upd_grant, 4'b0000);
      chk("t7_ftick", frame_tick, 1'b0);
      chk("t7_count", frame_count, 0);
      chk("t7_busy", busy, 1'b0);
      chk("t7_to_rst", timeout_err, 1'b0);
      chk("t7_ov_rst", overrun_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
